// File: rtl/vxe_vpu_actf_ctl_if.sv
// Bundle of signals between the VPU command decoder, the ACTF controller and
// the activation-function execution unit (actf_eu).
//   slave  : the controller. It takes i_* and drives o_*.
//   master : the environment. It is the decoder/EU side and drives i_*.
// Command : i_cmd_valid, o_cmd_ready, i_cmd_leaky, i_cmd_expd, i_th_en
// FMAC    : i_fmac_busy
// EU      : o_eu_start, i_eu_busy, o_eu_leaky, o_eu_expd
// Status  : o_busy, o_done, o_err, o_lat
interface vxe_vpu_actf_ctl_if #(
  parameter int LAT_W = 16
);
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic             i_cmd_leaky;
  logic [6:0]       i_cmd_expd;
  logic [7:0]       i_th_en;
  logic             i_fmac_busy;
  logic             o_eu_start;
  logic             i_eu_busy;
  logic             o_eu_leaky;
  logic [6:0]       o_eu_expd;
  logic             o_busy;
  logic             o_done;
  logic             o_err;
  logic [LAT_W-1:0] o_lat;

  modport slave (
    input  i_cmd_valid, i_cmd_leaky, i_cmd_expd, i_th_en, i_fmac_busy, i_eu_busy,
    output o_cmd_ready, o_eu_start, o_eu_leaky, o_eu_expd, o_busy, o_done, o_err, o_lat
  );

  modport master (
    output i_cmd_valid, i_cmd_leaky, i_cmd_expd, i_th_en, i_fmac_busy, i_eu_busy,
    input  o_cmd_ready, o_eu_start, o_eu_leaky, o_eu_expd, o_busy, o_done, o_err, o_lat
  );
endinterface

// File: rtl/vxe_vpu_actf_ctl.sv
// ACTF command sequencer. It accepts one activation command at a time and
// waits for the FMAC pipeline to drain. Then it fires a one-cycle start to
// actf_eu, tracks the EU busy window and reports done/timeout. It also keeps
// the start-to-busy-fall latency.
// Ports:
//   clk, nrst : clock and asynchronous active-low reset
//   bus       : vxe_vpu_actf_ctl_if.slave (command, FMAC, EU and status)
// Parameters:
//   BUSY_TMO  : the most cycles allowed from the start pulse to EU busy rising (>=2)
//   LAT_W     : width of the saturating latency counter. Must match bus LAT_W.
module vxe_vpu_actf_ctl #(
  parameter int BUSY_TMO = 16,
  parameter int LAT_W    = 16
) (
  input  logic              clk,
  input  logic              nrst,
  vxe_vpu_actf_ctl_if.slave bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DRAIN     = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [LAT_W-1:0] CNT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] CNT_MAX  = {LAT_W{1'b1}};
  // The counter reads 1 in the first WAIT_BUSY cycle. When it reaches
  // BUSY_TMO-1, this is the last cycle in which busy may still rise.
  localparam logic [LAT_W-1:0] TMO_LAST = LAT_W'(BUSY_TMO - 1);

  logic [2:0]       state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_inc, lat_q;
  logic             start_q, done_q, err_q, leaky_q;
  logic [6:0]       expd_q;
  logic             accept, timeout;

  assign accept  = (state_q == S_IDLE) && bus.i_cmd_valid;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // NOTE: every signal driven here gets a default before the case statement.
  // A path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_cmd_valid) begin
          state_d = (bus.i_th_en == 8'h00) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!bus.i_fmac_busy) state_d = S_START;
      end
      S_START: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        // A busy rise in the last allowed cycle beats the timeout.
        if (bus.i_eu_busy) begin
          state_d = S_RUN;
        end else if (cnt_q >= TMO_LAST) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        if (!bus.i_eu_busy) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from the pre-edge values and do not race each other.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      leaky_q <= 1'b0;
      expd_q  <= '0;
    end else begin
      state_q <= state_d;
      // Pulses are registered from the next state. Each one is high during
      // exactly the cycle the FSM spends in that state.
      start_q <= (state_d == S_START);
      done_q  <= (state_d == S_DONE);
      err_q   <= timeout;

      if (accept) begin
        leaky_q <= bus.i_cmd_leaky;
        expd_q  <= bus.i_cmd_expd;
      end

      if (state_q == S_START) begin
        cnt_q <= CNT_ONE;
      end else if (state_q == S_WAIT_BUSY || state_q == S_RUN) begin
        cnt_q <= cnt_inc;
      end

      // At the busy-fall cycle the counter equals cycles since the start pulse.
      if (state_q == S_RUN && !bus.i_eu_busy) begin
        lat_q <= cnt_q;
      end
    end
  end

  assign bus.o_cmd_ready = (state_q == S_IDLE);
  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_eu_start  = start_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;
  assign bus.o_eu_leaky  = leaky_q;
  assign bus.o_eu_expd   = expd_q;
  assign bus.o_lat       = lat_q;

endmodule

// File: tb/tb_vxe_vpu_actf_ctl.sv
// Self-checking bench for vxe_vpu_actf_ctl.
// The bench uses a small LAT_W so that latency saturation can be reached, and
// a short BUSY_TMO so that timeouts stay short.
module tb_vxe_vpu_actf_ctl;
  localparam int BUSY_TMO = 6;
  localparam int LAT_W    = 4;
  localparam int LAT_MAX  = (1 << LAT_W) - 1;
  localparam int BUDGET   = 200;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  vxe_vpu_actf_ctl_if #(.LAT_W(LAT_W)) bus ();

  vxe_vpu_actf_ctl #(.BUSY_TMO(BUSY_TMO), .LAT_W(LAT_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // One command and what it should produce. Offsets are in cycles and are
  // relative to the accept cycle. A start offset of -1 means no start pulse.
  // A rise of 0 means the EU never raises busy.
  typedef struct {
    logic       leaky;
    logic [6:0] expd;
    logic [7:0] th_en;
    int         drain;
    int         rise;
    int         len;
    int         exp_start;
    int         exp_done;
    int         exp_err;
    int         exp_lat;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cur_lat  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model. It works from the command timing rules, not the FSM.
  // Accept is cycle 0. The FMAC stays busy for 'drain' cycles, and the start
  // comes two cycles after the drain ends. Busy must rise within BUSY_TMO-1
  // cycles of start. Latency is start to busy fall, and done follows one
  // cycle after that.
  function automatic void model(input vec_t v, input int prev_lat,
                                output int st, output int dn, output int err, output int lat);
    if (v.th_en == 8'h00) begin
      st = -1; dn = 1; err = 0; lat = prev_lat;
    end else begin
      st = v.drain + 2;
      if (v.rise > 0 && v.rise < BUSY_TMO) begin
        dn  = st + v.rise + v.len + 1;
        err = 0;
        lat = (v.rise + v.len > LAT_MAX) ? LAT_MAX : v.rise + v.len;
      end else begin
        dn = st + BUSY_TMO; err = 1; lat = prev_lat;
      end
    end
  endfunction

  // Runs one command from IDLE until o_done, acting as decoder, FMAC and EU.
  // Command inputs are scrambled outside the accept cycle, stray EU busy is
  // driven before the start, and FMAC busy toggles after the start. The DUT
  // must ignore all of these.
  task automatic run_cmd(input vec_t v, output int st_off, output int n_start,
                         output int dn_off, output int err, output int lat,
                         output int hold_bad);
    int s;
    s = -1; st_off = -1; n_start = 0; dn_off = -1; err = 0; lat = -1; hold_bad = 0;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_leaky = v.leaky;
    bus.i_cmd_expd  = v.expd;
    bus.i_th_en     = v.th_en;
    bus.i_fmac_busy = (v.drain > 0);
    bus.i_eu_busy   = 1'($urandom);
    @(negedge clk);
    check("ready_before_accept", int'(bus.o_cmd_ready), 1);
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      bus.i_cmd_valid = 1'($urandom);
      bus.i_cmd_leaky = 1'($urandom);
      bus.i_cmd_expd  = 7'($urandom);
      bus.i_th_en     = 8'($urandom);
      if (s < 0) begin
        bus.i_fmac_busy = (k <= v.drain);
        bus.i_eu_busy   = 1'($urandom);
      end else begin
        bus.i_fmac_busy = 1'($urandom);
        bus.i_eu_busy   = (v.rise > 0) && (k >= s + v.rise) && (k < s + v.rise + v.len);
      end
      @(negedge clk);
      if (bus.o_eu_leaky !== v.leaky || bus.o_eu_expd !== v.expd) hold_bad++;
      if (bus.o_eu_start) begin
        n_start++;
        if (s < 0) begin s = k; st_off = k; end
      end
      if (bus.o_done) begin
        dn_off = k; err = int'(bus.o_err); lat = int'(bus.o_lat);
        break;
      end else if (bus.o_err) begin
        err = 2;
      end
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_fmac_busy = 1'b0;
    bus.i_eu_busy   = 1'b0;
  endtask

  task automatic apply(input string tag, input vec_t v);
    int st, ns, dn, er, lt, hb;
    run_cmd(v, st, ns, dn, er, lt, hb);
    check({tag, "_start_cycle"}, st, v.exp_start);
    check({tag, "_start_count"}, ns, (v.exp_start < 0) ? 0 : 1);
    check({tag, "_done_cycle"},  dn, v.exp_done);
    check({tag, "_err"},         er, v.exp_err);
    check({tag, "_lat"},         lt, v.exp_lat);
    check({tag, "_leaky_expd_hold"}, hb, 0);
    cur_lat = v.exp_lat;
  endtask

  vec_t vecs[6];
  vec_t e7;
  vec_t rv;

  initial begin
    int found, dones;
    //           leaky expd    th_en  drn rise len start done err lat
    vecs[0] = '{1'b0, 7'd0,  8'h01, 0,  2,  11,  2,  16, 0, 13};  // basic ReLU
    vecs[1] = '{1'b1, 7'd3,  8'h3C, 5,  1,  3,   7,  12, 0, 4};   // drain wait
    vecs[2] = '{1'b1, 7'd9,  8'h00, 0,  1,  3,  -1,  1,  0, 4};   // empty mask
    vecs[3] = '{1'b0, 7'd17, 8'hFF, 0,  0,  0,   2,  8,  1, 4};   // timeout
    vecs[4] = '{1'b1, 7'd64, 8'h80, 1,  3,  20,  3,  27, 0, 15};  // saturation
    vecs[5] = '{1'b0, 7'd127,8'h10, 0,  5,  1,   2,  9,  0, 6};   // last-chance busy
    e7      = '{1'b1, 7'd42, 8'hE7, 2,  1,  1,   4,  7,  0, 2};   // after mid-run reset

    bus.i_cmd_valid = 1'b0; bus.i_cmd_leaky = 1'b0; bus.i_cmd_expd = '0;
    bus.i_th_en = '0; bus.i_fmac_busy = 1'b0; bus.i_eu_busy = 1'b0;

    // Reset idle.
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  int'(bus.o_cmd_ready), 1);
    check("rst_busy",   int'(bus.o_busy), 0);
    check("rst_start",  int'(bus.o_eu_start), 0);
    check("rst_done",   int'(bus.o_done), 0);
    check("rst_err",    int'(bus.o_err), 0);
    check("rst_leaky",  int'(bus.o_eu_leaky), 0);
    check("rst_expd",   int'(bus.o_eu_expd), 0);
    check("rst_lat",    int'(bus.o_lat), 0);
    nrst = 1'b1;

    for (int i = 0; i < 6; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Reset while the EU is running.
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b1; bus.i_cmd_leaky = 1'b1; bus.i_cmd_expd = 7'd5; bus.i_th_en = 8'h01;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_eu_start) begin found = 1; break; end
    end
    check("midrst_start_seen", found, 1);
    @(posedge clk); #1;
    bus.i_eu_busy = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("midrst_busy_before", int'(bus.o_busy), 1);
    nrst = 1'b0;
    #1;
    check("midrst_busy",  int'(bus.o_busy), 0);
    check("midrst_ready", int'(bus.o_cmd_ready), 1);
    check("midrst_start", int'(bus.o_eu_start), 0);
    check("midrst_lat",   int'(bus.o_lat), 0);
    check("midrst_leaky", int'(bus.o_eu_leaky), 0);
    bus.i_eu_busy = 1'b0;
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_done) dones++;
    end
    nrst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.o_done) dones++;
    end
    check("midrst_no_done", dones, 0);
    cur_lat = 0;
    apply("e7", e7);

    // Randomized commands checked against the reference model.
    for (int n = 0; n < 40; n++) begin
      int st, dn, er, lt;
      rv.leaky = 1'($urandom);
      rv.expd  = 7'($urandom);
      rv.th_en = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rv.drain = $urandom_range(0, 4);
      rv.rise  = $urandom_range(0, BUSY_TMO + 1);
      rv.len   = $urandom_range(1, 25);
      model(rv, cur_lat, st, dn, er, lt);
      rv.exp_start = st; rv.exp_done = dn; rv.exp_err = er; rv.exp_lat = lt;
      apply($sformatf("rnd%0d", n), rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
